// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences PLL reset, lock qualification and memory-domain reset release
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int LOSS_W        = 8,
  localparam int TMAX = (RST_CYCLES > LOCK_TIMEOUT) ?
                        ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES) :
                        ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES),
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              restart,
  output logic              pll_reset,
  output logic              mem_reset_n,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state,
  output logic [RW-1:0]     retry_count,
  output logic [LOSS_W-1:0] lock_loss_count
);
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              sync1_q, lock_s_q;

  // two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end

  // state, timer and counter registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RESET_PLL;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end

  // next state: restart overrides everything; lock drop beats STABLE completion
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = RESET_PLL;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          state_d = (timer_q == TW'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
          timer_d = (timer_q == TW'(RST_CYCLES - 1)) ? '0 : timer_q + TW'(1);
        end
        WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = (retry_q == RW'(MAX_RETRIES)) ? FAULT : RESET_PLL;
            retry_d = (retry_q == RW'(MAX_RETRIES)) ? retry_q : retry_q + RW'(1);
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        STABLE: begin
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
            state_d = READY;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        READY: begin
          if (!lock_s_q) begin
            state_d = RESET_PLL;
            timer_d = '0;
            loss_d  = (&loss_q) ? loss_q : loss_q + LOSS_W'(1);
          end
        end
        FAULT: ;
        default: begin
          state_d = RESET_PLL;
          timer_d = '0;
        end
      endcase
    end
  end

  assign pll_reset       = (state_q == RESET_PLL);
  assign ready           = (state_q == READY);
  assign mem_reset_n     = (state_q == READY);
  assign fault           = (state_q == FAULT);
  assign state           = state_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, mem_reset_n, ready, fault;
  logic [2:0] state;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  int         checks = 0;
  int         errors = 0;
  int         n;

  pll_lock_sequencer #(
    .RST_CYCLES(16), .LOCK_TIMEOUT(64), .STABLE_CYCLES(32), .MAX_RETRIES(2), .LOSS_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset), .mem_reset_n(mem_reset_n), .ready(ready), .fault(fault),
    .state(state), .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // counts negedges spent in state s, leaving the caller on the first negedge outside it
  task automatic count_while(input logic [2:0] s, input int limit, output int cnt);
    cnt = 0;
    while (state == s && cnt < limit) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // counts negedges until state s is observed
  task automatic wait_for(input logic [2:0] s, input int limit, output int cnt);
    cnt = 0;
    while (state != s && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_mem_reset_n", mem_reset_n, 0);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_count, 0);
    check("rst_loss", lock_loss_count, 0);
    reset_n = 1'b1;
    // normal lock: pll_reset for 16 cycles, lock 10 cycles later
    count_while(3'd0, 100, n);
    check("pll_reset_width", n, 16);
    check("wait_pll_reset_low", pll_reset, 0);
    repeat (10) @(negedge clk);
    check("still_wait_lock", state, 1);
    pll_lock = 1'b1;
    wait_for(3'd2, 10, n);
    check("sync_latency", n, 3);
    count_while(3'd2, 100, n);
    check("stable_len", n, 32);
    check("ready_state", state, 3);
    check("ready_out", ready, 1);
    check("ready_mem_reset_n", mem_reset_n, 1);
    check("ready_retry", retry_count, 0);
    // single lock loss
    pll_lock = 1'b0;
    wait_for(3'd0, 10, n);
    check("loss_latency", n, 3);
    check("loss_mem_reset_n", mem_reset_n, 0);
    check("loss_count1", lock_loss_count, 1);
    count_while(3'd0, 100, n);
    check("loss_pulse_width", n, 16);
    pll_lock = 1'b1;
    wait_for(3'd2, 10, n);
    check("relock_latency", n, 3);
    // one-cycle glitch at stable count 20
    repeat (19) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_for(3'd1, 10, n);
    check("glitch_to_wait", n, 2);
    check("glitch_ready", ready, 0);
    wait_for(3'd2, 10, n);
    check("glitch_back_stable", n, 1);
    count_while(3'd2, 100, n);
    check("glitch_full_stable", n, 32);
    check("glitch_ready_after", ready, 1);
    // repeated losses until saturation (260 total)
    for (int i = 2; i <= 260; i++) begin
      pll_lock = 1'b0;
      wait_for(3'd0, 10, n);
      wait_for(3'd1, 40, n);
      pll_lock = 1'b1;
      wait_for(3'd3, 60, n);
      if (i == 10) check("loss_count10", lock_loss_count, 10);
    end
    check("loss_loop_ready", state, 3);
    check("loss_saturated", lock_loss_count, 255);
    // timeout to fault: three attempts
    pll_lock = 1'b0;
    wait_for(3'd0, 10, n);
    check("loss_stays_saturated", lock_loss_count, 255);
    count_while(3'd0, 100, n);
    check("attempt1_pulse", n, 16);
    check("attempt1_retry", retry_count, 0);
    count_while(3'd1, 200, n);
    check("timeout1_len", n, 64);
    check("timeout1_state", state, 0);
    check("retry_1", retry_count, 1);
    count_while(3'd0, 100, n);
    check("attempt2_pulse", n, 16);
    count_while(3'd1, 200, n);
    check("timeout2_len", n, 64);
    check("retry_2", retry_count, 2);
    count_while(3'd0, 100, n);
    check("attempt3_pulse", n, 16);
    count_while(3'd1, 200, n);
    check("timeout3_len", n, 64);
    check("fault_state", state, 4);
    check("fault_out", fault, 1);
    check("fault_pll_reset", pll_reset, 0);
    check("fault_mem_reset_n", mem_reset_n, 0);
    repeat (50) @(negedge clk);
    check("fault_held", state, 4);
    // restart from fault
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_state", state, 0);
    check("restart_fault", fault, 0);
    check("restart_retry", retry_count, 0);
    check("restart_loss_kept", lock_loss_count, 255);
    count_while(3'd0, 100, n);
    check("restart_pulse", n, 16);
    // restart coincident with the WAIT_LOCK timeout edge
    repeat (63) @(negedge clk);
    check("pre_timeout_state", state, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_timeout_state", state, 0);
    check("restart_timeout_retry", retry_count, 0);
    count_while(3'd0, 100, n);
    check("restart_timeout_pulse", n, 16);
    // asynchronous reset mid-STABLE, off the clock edge
    pll_lock = 1'b1;
    wait_for(3'd2, 10, n);
    repeat (5) @(negedge clk);
    check("pre_async_state", state, 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_pll_reset", pll_reset, 1);
    check("async_mem_reset_n", mem_reset_n, 0);
    check("async_ready", ready, 0);
    check("async_retry", retry_count, 0);
    check("async_loss", lock_loss_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_while(3'd0, 100, n);
    check("post_reset_pulse", n, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
